// File: rtl/amm_mem_responder_pkg.sv
// amm_mem_responder_pkg
// Shared widths, parameter defaults and the responder state encoding.
//   AMM_ADDR_W / AMM_DATA_W / AMM_BURST_W / DATA_B_W : Avalon-MM bus widths
//   RD_LATENCY_DEF / WAIT_PERIOD_DEF                  : responder parameter defaults
//   amm_state_e                                       : responder FSM states
//   burst_len()                                       : burstcount with 0 mapped to 1
package amm_mem_responder_pkg;

  localparam int unsigned AMM_ADDR_W      = 32;
  localparam int unsigned AMM_DATA_W      = 32;
  localparam int unsigned AMM_BURST_W     = 8;
  localparam int unsigned DATA_B_W        = AMM_DATA_W / 8;

  localparam int unsigned RD_LATENCY_DEF  = 4;
  localparam int unsigned WAIT_PERIOD_DEF = 0;

  typedef enum logic [1:0] {
    StIdle,
    StWrBurst,
    StRdBurst,
    StRdDrain
  } amm_state_e;

  // A burstcount of zero is treated as a single beat.
  function automatic logic [AMM_BURST_W-1:0] burst_len(input logic [AMM_BURST_W-1:0] bc);
    return (bc == '0) ? AMM_BURST_W'(1) : bc;
  endfunction

endpackage

// File: rtl/amm_rd_delay_line.sv
// amm_rd_delay_line
// (valid, data) shift register that sits after the 1-cycle RAM read register and
// stretches the read path to the configured total latency.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (flushes all stages)
//   i_valid/i_data : beat coming out of the RAM read register
//   o_valid/o_data : beat presented on the Avalon read-data port
//   o_empty        : no beat is pending behind the one currently on o_valid
module amm_rd_delay_line #(
  parameter int unsigned STAGES = 3,
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_empty
);

  if (STAGES == 0) begin : g_pass
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = i_clk ^ i_rst_n;
    assign o_valid = i_valid;
    assign o_data  = i_data;
    // The input itself is the visible beat, so nothing can be waiting behind it.
    assign o_empty = 1'b1;
  end else begin : g_pipe
    logic [STAGES-1:0] r_vld;
    logic [DATA_W-1:0] r_data [STAGES];
    logic              w_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_vld <= '0;
        for (int i = 0; i < int'(STAGES); i++) r_data[i] <= '0;
      end else begin
        r_vld[0]  <= i_valid;
        r_data[0] <= i_data;
        for (int i = 1; i < int'(STAGES); i++) begin
          r_vld[i]  <= r_vld[i-1];
          r_data[i] <= r_data[i-1];
        end
      end
    end

    // The last stage is what the master sees; only earlier stages count as pending.
    always_comb begin
      w_empty = !i_valid;
      for (int i = 0; i < int'(STAGES) - 1; i++) begin
        if (r_vld[i]) w_empty = 1'b0;
      end
    end

    assign o_valid = r_vld[STAGES-1];
    assign o_data  = r_data[STAGES-1];
    assign o_empty = w_empty;
  end

endmodule

// File: rtl/amm_mem_responder.sv
// amm_mem_responder
// Avalon-MM burst responder backed by an internal RAM, with programmable read latency,
// periodic waitrequest stalls and single-word read corruption.
//   clk_i, rst_i                      : clock, asynchronous active-low reset
//   read_i, write_i, address_i        : Avalon command
//   writedata_i, byteenable_i         : write data with per-byte enables
//   burstcount_i                      : burst length in beats (0 means 1)
//   waitrequest_o                     : registered stall / busy indication
//   readdata_o, readdatavalid_o       : read response beats
//   fault_en_i, fault_addr_i, fault_mask_i : XOR corruption of one word on read
module amm_mem_responder
  import amm_mem_responder_pkg::*;
#(
  parameter int unsigned MEM_DEPTH_W = 10,
  parameter int unsigned RD_LATENCY  = RD_LATENCY_DEF,
  parameter int unsigned WAIT_PERIOD = WAIT_PERIOD_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   read_i,
  input  logic                   write_i,
  input  logic [AMM_ADDR_W-1:0]  address_i,
  input  logic [AMM_DATA_W-1:0]  writedata_i,
  input  logic [AMM_BURST_W-1:0] burstcount_i,
  input  logic [DATA_B_W-1:0]    byteenable_i,
  output logic                   waitrequest_o,
  output logic [AMM_DATA_W-1:0]  readdata_o,
  output logic                   readdatavalid_o,
  input  logic                   fault_en_i,
  input  logic [MEM_DEPTH_W-1:0] fault_addr_i,
  input  logic [AMM_DATA_W-1:0]  fault_mask_i
);

  localparam int unsigned MemWords = 2 ** MEM_DEPTH_W;
  localparam int unsigned CntW     = 16;

  amm_state_e             r_state;
  logic [MEM_DEPTH_W-1:0] r_addr;
  logic [AMM_BURST_W-1:0] r_cnt;
  logic                   r_wait;
  logic [CntW-1:0]        r_stall_cnt;
  logic [CntW-1:0]        w_stall_cnt_d;
  logic                   w_stall_d;

  logic [AMM_DATA_W-1:0]  r_mem [MemWords];
  logic                   r_ram_vld;
  logic [AMM_DATA_W-1:0]  r_ram_data;
  logic                   w_dl_empty;

  logic [MEM_DEPTH_W-1:0] w_addr_lo;
  logic [AMM_BURST_W-1:0] w_len;
  logic                   w_acc_wr;
  logic                   w_acc_rd;
  logic                   w_wr_en;
  logic                   w_rd_issue;
  logic [MEM_DEPTH_W-1:0] w_wr_addr;
  logic [MEM_DEPTH_W-1:0] w_rd_addr;
  logic [AMM_DATA_W-1:0]  w_fault_mask;
  logic                   w_unused_addr;

  // Upper address bits are ignored, so the array aliases across the address space.
  assign w_addr_lo     = address_i[MEM_DEPTH_W-1:0];
  assign w_unused_addr = ^address_i[AMM_ADDR_W-1:MEM_DEPTH_W];
  assign w_len         = burst_len(burstcount_i);
  // Write wins over a simultaneous read.
  assign w_acc_wr      = write_i & ~r_wait;
  assign w_acc_rd      = read_i & ~write_i & ~r_wait;

  always_comb begin
    w_wr_en    = 1'b0;
    w_wr_addr  = w_addr_lo;
    w_rd_issue = 1'b0;
    w_rd_addr  = w_addr_lo;
    case (r_state)
      StIdle: begin
        w_wr_en    = w_acc_wr;
        // Beat 0 is issued in the accept cycle so the first beat lands RD_LATENCY later.
        w_rd_issue = w_acc_rd;
      end
      StWrBurst: begin
        w_wr_en   = w_acc_wr;
        w_wr_addr = r_addr;
      end
      StRdBurst: begin
        w_rd_issue = 1'b1;
        w_rd_addr  = r_addr;
      end
      default: ;
    endcase
  end

  // Free-running stall counter; a stall is flagged for the cycle the counter hits its top.
  always_comb begin
    if (WAIT_PERIOD >= 2) begin
      w_stall_cnt_d = (r_stall_cnt == CntW'(WAIT_PERIOD - 1)) ? '0 : r_stall_cnt + 1'b1;
      w_stall_d     = (w_stall_cnt_d == CntW'(WAIT_PERIOD - 1));
    end else begin
      w_stall_cnt_d = '0;
      w_stall_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_wait      <= 1'b1;
      r_stall_cnt <= '0;
    end else begin
      r_stall_cnt <= w_stall_cnt_d;
      r_wait      <= w_stall_d;
      case (r_state)
        StIdle: begin
          if (w_acc_wr) begin
            if (w_len != AMM_BURST_W'(1)) begin
              r_state <= StWrBurst;
              r_addr  <= w_addr_lo + 1'b1;
              r_cnt   <= w_len - 1'b1;
            end
          end else if (w_acc_rd) begin
            r_addr  <= w_addr_lo + 1'b1;
            r_cnt   <= w_len - 1'b1;
            r_wait  <= 1'b1;
            r_state <= (w_len == AMM_BURST_W'(1)) ? StRdDrain : StRdBurst;
          end
        end
        StWrBurst: begin
          if (w_acc_wr) begin
            r_addr <= r_addr + 1'b1;
            r_cnt  <= r_cnt - 1'b1;
            if (r_cnt == AMM_BURST_W'(1)) r_state <= StIdle;
          end
        end
        StRdBurst: begin
          r_wait <= 1'b1;
          r_addr <= r_addr + 1'b1;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == AMM_BURST_W'(1)) r_state <= StRdDrain;
        end
        StRdDrain: begin
          // Leave while the final beat is on the port so waitrequest drops right after it.
          if (w_dl_empty) r_state <= StIdle;
          else            r_wait  <= 1'b1;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      for (int b = 0; b < int'(DATA_B_W); b++) begin
        if (byteenable_i[b]) r_mem[w_wr_addr][b*8 +: 8] <= writedata_i[b*8 +: 8];
      end
    end
  end

  // Corruption is decided at issue time, using fault_en_i as it is when the beat is read.
  assign w_fault_mask = (fault_en_i && (w_rd_addr == fault_addr_i)) ? fault_mask_i : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ram_vld  <= 1'b0;
      r_ram_data <= '0;
    end else begin
      r_ram_vld <= w_rd_issue;
      if (w_rd_issue) r_ram_data <= r_mem[w_rd_addr] ^ w_fault_mask;
    end
  end

  amm_rd_delay_line #(
    .STAGES (RD_LATENCY - 1),
    .DATA_W (AMM_DATA_W)
  ) u_rd_delay_line (
    .i_clk   (clk_i),
    .i_rst_n (rst_i),
    .i_valid (r_ram_vld),
    .i_data  (r_ram_data),
    .o_valid (readdatavalid_o),
    .o_data  (readdata_o),
    .o_empty (w_dl_empty)
  );

  assign waitrequest_o = r_wait;

  a_no_read_in_wr_burst: assert property (
    @(posedge clk_i) disable iff (!rst_i) (r_state == StWrBurst) |-> !read_i);
  a_no_read_write_idle: assert property (
    @(posedge clk_i) disable iff (!rst_i) (r_state == StIdle) |-> !(read_i && write_i));

endmodule

// File: tb/tb_amm_mem_responder.sv
module tb_amm_mem_responder;
  import amm_mem_responder_pkg::*;

  localparam int unsigned DepthW = 10;
  localparam int unsigned Words  = 2 ** DepthW;
  localparam int          RdLat  = 4;
  localparam int          WaitP  = 3;

  logic                   clk;
  logic                   rst_n;
  logic                   rd;
  logic                   wr;
  logic [AMM_ADDR_W-1:0]  address;
  logic [AMM_DATA_W-1:0]  writedata;
  logic [AMM_BURST_W-1:0] burstcount;
  logic [DATA_B_W-1:0]    byteenable;
  logic                   waitrequest;
  logic [AMM_DATA_W-1:0]  readdata;
  logic                   readdatavalid;
  logic                   fault_en;
  logic [DepthW-1:0]      fault_addr;
  logic [AMM_DATA_W-1:0]  fault_mask;

  amm_mem_responder #(
    .MEM_DEPTH_W (DepthW),
    .RD_LATENCY  (RdLat),
    .WAIT_PERIOD (WaitP)
  ) u_dut (
    .clk_i           (clk),
    .rst_i           (rst_n),
    .read_i          (rd),
    .write_i         (wr),
    .address_i       (address),
    .writedata_i     (writedata),
    .burstcount_i    (burstcount),
    .byteenable_i    (byteenable),
    .waitrequest_o   (waitrequest),
    .readdata_o      (readdata),
    .readdatavalid_o (readdatavalid),
    .fault_en_i      (fault_en),
    .fault_addr_i    (fault_addr),
    .fault_mask_i    (fault_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock edges since reset release; the responder's stall counter equals cyc mod WaitP.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int total;
  int bad;

  logic [31:0] mem_m [Words];

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } beat_t;
  beat_t exp_q[$];
  beat_t mon_b;

  typedef struct {
    int unsigned wa;
    int unsigned ra;
    logic [31:0] old;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[5];

  function automatic logic stall_exp(input int c);
    return (c % WaitP) == (WaitP - 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (readdatavalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got readdatavalid=1 data %h want no beat (cyc %0d)",
                 readdata, cyc);
      end else begin
        mon_b = exp_q.pop_front();
        check("beat_cycle", cyc, mon_b.cyc);
        check("beat_data", readdata, mon_b.data);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the last accepted beat.
  task automatic wr_burst(input int unsigned addr, input int unsigned len,
                          input logic [3:0] be, input bit rnd, input logic [31:0] base);
    int unsigned n = (len == 0) ? 1 : len;
    int unsigned i = 0;
    int unsigned a;
    int          guard = 0;
    wr         = 1'b1;
    address    = addr;
    burstcount = AMM_BURST_W'(len);
    byteenable = be;
    writedata  = rnd ? $urandom : base;
    while (i < n) begin
      check("wait_stall_wr", waitrequest, stall_exp(cyc));
      if (waitrequest === 1'b0) begin
        a = (addr + i) % Words;
        for (int k = 0; k < 4; k++) if (be[k]) mem_m[a][k*8 +: 8] = writedata[k*8 +: 8];
        i++;
      end
      guard++;
      if (guard > int'(3 * n + 8)) begin
        total++;
        bad++;
        $display("FAIL wr_timeout: got %0d beats want %0d", i, n);
        break;
      end
      @(negedge clk);
      writedata = rnd ? $urandom : base + i;
    end
    wr = 1'b0;
  endtask

  // Expected beats come from the model memory unless use_exp forces a fixed value.
  task automatic rd_burst(input int unsigned addr, input int unsigned len,
                          input bit use_exp, input logic [31:0] exp);
    int unsigned n = (len == 0) ? 1 : len;
    int unsigned a;
    int          guard = 0;
    int          t;
    logic [31:0] d;
    beat_t       bt;
    rd         = 1'b1;
    address    = addr;
    burstcount = AMM_BURST_W'(len);
    check("wait_stall_rd", waitrequest, stall_exp(cyc));
    while (waitrequest !== 1'b0) begin
      guard++;
      if (guard > 8) begin
        total++;
        bad++;
        $display("FAIL rd_accept_timeout: got waitrequest=%b want 0", waitrequest);
        rd = 1'b0;
        return;
      end
      @(negedge clk);
      check("wait_stall_rd", waitrequest, stall_exp(cyc));
    end
    t = cyc;
    for (int unsigned k = 0; k < n; k++) begin
      a = (addr + k) % Words;
      d = mem_m[a];
      if (fault_en && a == 32'(fault_addr)) d = d ^ fault_mask;
      if (use_exp) d = exp;
      bt.cyc  = t + RdLat + int'(k);
      bt.data = d;
      exp_q.push_back(bt);
    end
    @(negedge clk);
    rd = 1'b0;
    while (cyc < t + RdLat + int'(n)) @(negedge clk);
    check("beats_missing", exp_q.size(), 0);
    exp_q.delete();
    check("wait_release", waitrequest, stall_exp(cyc));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned ra;
    int unsigned rl;
    int          guard;
    total      = 0;
    bad        = 0;
    rst_n      = 1'b1;
    rd         = 1'b0;
    wr         = 1'b0;
    address    = '0;
    writedata  = '0;
    burstcount = '0;
    byteenable = '0;
    fault_en   = 1'b0;
    fault_addr = '0;
    fault_mask = '0;

    vecs[0] = '{wa: 5,      ra: 5,      old: 32'h0,        wd: 32'hA5A5_0001, be: 4'hF,
                exp: 32'hA5A5_0001};
    vecs[1] = '{wa: 7,      ra: 7,      old: 32'h0,        wd: 32'hFFFF_FFFF, be: 4'h1,
                exp: 32'h0000_00FF};
    vecs[2] = '{wa: 9,      ra: 9,      old: 32'h1234_5678, wd: 32'hFFFF_FFFF, be: 4'hA,
                exp: 32'hFF34_FF78};
    vecs[3] = '{wa: 'h40A,  ra: 'h00A,  old: 32'h0,        wd: 32'hCAFE_F00D, be: 4'hF,
                exp: 32'hCAFE_F00D};
    vecs[4] = '{wa: 'h10,   ra: 'h810,  old: 32'hDEAD_BEEF, wd: 32'h0,         be: 4'h6,
                exp: 32'hDE00_00EF};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_waitrequest", waitrequest, 1'b1);
    check("rst_readdatavalid", readdatavalid, 1'b0);
    check("rst_readdata", readdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("wait_after_reset", waitrequest, 1'b0);

    // Fill the whole array so every later read has a defined model value.
    for (int j = 0; j < 8; j++) wr_burst(j * 128, 128, 4'hF, 1'b1, 32'h0);

    for (int v = 0; v < 5; v++) begin
      wr_burst(vecs[v].wa, 1, 4'hF, 1'b0, vecs[v].old);
      wr_burst(vecs[v].wa, 1, vecs[v].be, 1'b0, vecs[v].wd);
      rd_burst(vecs[v].ra, 1, 1'b1, vecs[v].exp);
    end

    // Burst wrapping past the top of the array.
    wr_burst('h3FC, 8, 4'hF, 1'b0, 32'hB000_0000);
    rd_burst('h3FC, 8, 1'b0, 32'h0);
    rd_burst('h3FF, 1, 1'b1, 32'hB000_0003);
    rd_burst('h000, 1, 1'b1, 32'hB000_0004);
    rd_burst('h003, 1, 1'b1, 32'hB000_0007);

    // Fault injection on word 2 of a 4-beat burst.
    wr_burst(0, 4, 4'hF, 1'b0, 32'h0000_0100);
    fault_en   = 1'b1;
    fault_addr = 10'd2;
    fault_mask = 32'h1;
    rd_burst(0, 4, 1'b0, 32'h0);
    rd_burst(2, 1, 1'b1, 32'h0000_0103);
    rd_burst(1, 1, 1'b1, 32'h0000_0101);
    fault_en = 1'b0;
    rd_burst(2, 1, 1'b1, 32'h0000_0102);

    // 6-beat write burst across periodic stalls, then read back.
    wr_burst('h200, 6, 4'hF, 1'b1, 32'h0);
    rd_burst('h200, 6, 1'b0, 32'h0);
    rd_burst(0, 0, 1'b0, 32'h0);

    for (int r = 0; r < 40; r++) begin
      ra = $urandom;
      rl = $urandom_range(0, 12);
      if ($urandom_range(0, 1) == 0) begin
        wr_burst(ra, rl, 4'($urandom), 1'b1, 32'h0);
      end else begin
        fault_en   = ($urandom_range(0, 3) == 0);
        fault_addr = DepthW'(ra + $urandom_range(0, 3));
        fault_mask = $urandom;
        rd_burst(ra, rl, 1'b0, 32'h0);
        fault_en = 1'b0;
      end
    end

    // Reset two cycles after a burst-8 read is accepted.
    rd         = 1'b1;
    address    = 'h100;
    burstcount = 8'd8;
    guard      = 0;
    while (waitrequest !== 1'b0 && guard < 8) begin
      guard++;
      @(negedge clk);
    end
    check("rst_rd_accept", waitrequest, 1'b0);
    @(negedge clk);
    rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("midrst_waitrequest", waitrequest, 1'b1);
      check("midrst_readdatavalid", readdatavalid, 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_wait_release", waitrequest, 1'b0);
    for (int k = 0; k < 10; k++) begin
      check("midrst_no_valid", readdatavalid, 1'b0);
      @(negedge clk);
    end

    // Normal traffic after the abandoned burst.
    wr_burst('h50, 3, 4'hF, 1'b1, 32'h0);
    rd_burst('h50, 3, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/amm_mem_responder.md
# amm_mem_responder

Synthesizable Avalon-MM burst responder backed by an internal RAM. It is the far end of the memory interface that mem_checker drives: it accepts write and read bursts, returns read data with a configurable latency, inserts periodic waitrequest stalls, and can corrupt one chosen word on read. It is used as the memory under test in simulation and in on-chip loopback builds.

## Interface
Parameters:
- MEM_DEPTH_W, 10: word-address width of the internal array, giving 2^MEM_DEPTH_W words of AMM_DATA_W bits.
- RD_LATENCY, 4: cycles from read-command accept to the first readdatavalid_o. Legal range is ≥ 1.
- WAIT_PERIOD, 0: stall-injection period. 0 disables stalls; N ≥ 2 forces one stall cycle every N cycles.

Widths AMM_ADDR_W, AMM_DATA_W, AMM_BURST_W and DATA_B_W come from rtl_settings_pkg.

Ports:
- clk_i, in, 1: the single clock.
- rst_i, in, 1: reset, asynchronous and active-low.
- read_i, in, 1: Avalon read request.
- write_i, in, 1: Avalon write request.
- address_i, in, AMM_ADDR_W: word address.
- writedata_i, in, AMM_DATA_W: write data.
- burstcount_i, in, AMM_BURST_W: burst length in beats.
- byteenable_i, in, DATA_B_W: per-byte write enable.
- waitrequest_o, out, 1: responder is stalling the current request.
- readdata_o, out, AMM_DATA_W: read data.
- readdatavalid_o, out, 1: readdata_o holds a valid beat.
- fault_en_i, in, 1: enables read-data corruption.
- fault_addr_i, in, MEM_DEPTH_W: word address to corrupt.
- fault_mask_i, in, AMM_DATA_W: XOR mask applied to the corrupted word.

## Operation
- Address mapping: the array is indexed by address_i[MEM_DEPTH_W-1:0]. Upper bits are ignored, so addresses alias. The in-burst address increments modulo 2^MEM_DEPTH_W.
- Burst length: burstcount_i = 0 is treated as 1.
- Accept rule: a request is accepted on a cycle where (read_i | write_i) & !waitrequest_o.
- State machine states: IDLE, WR_BURST, RD_BURST, RD_DRAIN.
- IDLE, accepted write: the beat is written to the array. If the burst has more than 1 beat, the block latches base+1 and burstcount-1 remaining, then moves to WR_BURST.
- WR_BURST: each accepted write beat is written at the current address, then the address increments. write_i low is a bubble and changes nothing. After the last beat the state returns to IDLE. read_i in WR_BURST is ignored, and a simulation assertion fires.
- IDLE, accepted read: the block latches the address and the count, then moves to RD_BURST.
- RD_BURST: waitrequest_o is held at 1. The block issues one array read per cycle into the delay line. After the last beat is issued it moves to RD_DRAIN.
- RD_DRAIN: waitrequest_o is held at 1 until the delay line is empty, then the state returns to IDLE. Exactly one read burst is outstanding at a time.
- Write priority: read_i and write_i high together in IDLE is treated as a write. A simulation assertion fires.
- Byte enables: byte i of the word is written only if byteenable_i[i] is 1. Unwritten bytes keep their old value.
- Fault injection: when fault_en_i = 1 and a beat's word address equals fault_addr_i, readdata_o = stored ^ fault_mask_i. fault_en_i is sampled when the beat is issued, not when it is returned. Writes are never corrupted.
- Stall injection: a free-running counter counts 0 to WAIT_PERIOD-1. When WAIT_PERIOD ≥ 2 and the counter equals WAIT_PERIOD-1, waitrequest_o = 1 in IDLE and in WR_BURST.

## Timing
- Reset values: waitrequest_o = 1, readdatavalid_o = 0, readdata_o = 0, state = IDLE, counters = 0, delay line empty. Array contents are not reset.
- waitrequest_o is registered. It drops on the first clk_i edge after rst_i deasserts, unless a stall cycle is due.
- Write latency: data accepted at cycle T is readable by a command accepted at T+1.
- Read latency: command accepted at cycle T gives beat k with readdatavalid_o = 1 at T+RD_LATENCY+k. Beats are back-to-back with no gaps.
- After the last beat at cycle L, waitrequest_o = 0 at L+1, unless a stall cycle is due.
- Reset asserted mid-burst: the state machine goes to IDLE and the delay line flushes immediately. No further readdatavalid_o pulses occur, and a partial write burst is abandoned.

## Structure
- rtl_settings_pkg gains the state-encoding typedef and the RD_LATENCY and WAIT_PERIOD defaults.
- There is one sub-module, amm_rd_delay_line. It is a (valid, data) shift register of RD_LATENCY-1 stages placed after the 1-cycle synchronous RAM read, and it has its own empty flag.
- The RAM is an inferred array with per-byte write enables.

## Test plan
- Single write then read: write 0xA5A5_0001 at address 5 with burstcount 1, then read address 5 with burstcount 1. Required response: readdatavalid_o at T+4, and readdata_o = 0xA5A5_0001.
- Write burst of 8 at address 0x3FC with MEM_DEPTH_W = 10, then read the same burst. Required response: data lands at 0x3FC–0x3FF and 0x000–0x003 (wrap), and the read returns 8 beats, in order and contiguous.
- Byteenable: write all-ones data with byteenable = 0b0001 over a word that holds zero, then read it back. Required response: only byte 0 is 0xFF.
- Fault injection: fault_en_i = 1, fault_addr_i = 2, fault_mask_i = 1, over a read burst of 4 at address 0. Required response: beat 2 has bit 0 flipped, and the other beats are intact.
- Stalls: WAIT_PERIOD = 3 with a write burst of 6. Required response: waitrequest_o is high every third cycle, and all 6 beats are stored correctly.
- Reset mid-read: assert rst_i two cycles after a burst-8 read accept. Required response: no readdatavalid_o pulse, waitrequest_o = 1 during reset, and waitrequest_o = 0 one cycle after release.
